// File: rtl/rom_script_fetcher.sv
// rom_script_fetcher: walks a ROM script from a start address, absorbs the
// 1-cycle ROM latency and streams words through a small credit-managed FIFO.
// Optional feature macro: SCRIPT_FETCH_ABORT_EN adds an abort input.
module rom_script_fetcher #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] END_WORD   = 32'h0000_0000,
    parameter int unsigned ROM_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] start_addr,
`ifdef SCRIPT_FETCH_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        done,
    output logic        err_nomark,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned WW = $clog2(ROM_WORDS);
    localparam int unsigned NW = WW + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   word_q, word_d;
    logic [NW-1:0]   issued_q, issued_d;
    logic            s0_q, s0_d;
    logic            s1_q, s1_d;
    logic            marker_q, marker_d;
    logic [11:0]     rom_addr_q, rom_addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [PW:0]     count_q, count_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [31:0]     mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            is_mark;
    logic            credit;
    logic            abort_hit;
    logic [WW-1:0]   start_word;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^start_addr[1:0];
    assign start_word = start_addr[WW+1:2];

    assign cmd_valid  = (count_q != '0);
    assign cmd_data   = mem_q[rd_q];
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_nomark = err_q;
    assign rom_addr   = rom_addr_q;

    function automatic logic [WW-1:0] next_word(input logic [WW-1:0] w);
        if (w == WW'(ROM_WORDS - 1)) begin
            return '0;
        end
        return w + 1'b1;
    endfunction

    // next-state: sequencing, issue credit, capture and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        issued_d   = issued_q;
        s0_d       = 1'b0;
        s1_d       = s0_q;
        marker_d   = marker_q;
        rom_addr_d = rom_addr_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        abort_hit  = 1'b0;
        pop        = cmd_valid & cmd_ready;
        is_mark    = s1_q && (rom_data == END_WORD);
        push       = s1_q && (rom_data != END_WORD);
        credit     = (32'(count_q) + 32'(s0_q) + 32'(s1_q)) < FIFO_DEPTH;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    rom_addr_d = 12'({start_word, 2'b00});
                    word_d     = next_word(start_word);
                    issued_d   = NW'(1);
                    s0_d       = 1'b1;
                    marker_d   = 1'b0;
                end
            end
            FETCH: begin
                if (is_mark) begin
                    marker_d = 1'b1;
                    s1_d     = 1'b0;
                    state_d  = DRAIN;
                end else if (issued_q == NW'(ROM_WORDS)) begin
                    state_d = DRAIN;
                end else if (credit) begin
                    rom_addr_d = 12'({word_q, 2'b00});
                    word_d     = next_word(word_q);
                    issued_d   = issued_q + 1'b1;
                    s0_d       = 1'b1;
                end
            end
            DRAIN: begin
                if (is_mark) begin
                    marker_d = 1'b1;
                    s1_d     = 1'b0;
                end
                if (count_q == '0 && !s0_q && !s1_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase

        if (push) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

`ifdef SCRIPT_FETCH_ABORT_EN
        if (abort && (state_q == FETCH || state_q == DRAIN)) begin
            abort_hit = 1'b1;
            state_d   = DONE;
            s0_d      = 1'b0;
            s1_d      = 1'b0;
            push      = 1'b0;
            count_d   = '0;
            rd_d      = '0;
            wr_d      = '0;
        end
`endif

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        err_d  = (state_d == DONE) && !marker_d && !abort_hit;
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            issued_q   <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            marker_q   <= 1'b0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            issued_q   <= issued_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            marker_q   <= marker_d;
            rom_addr_q <= rom_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= rom_data;
        end
    end

endmodule
